// File: rtl/instr_buffer_if.sv
// Fetch/decode-side bundle for instr_buffer: two-lane enqueue from fetch, two-lane head view to decode.
// The buffer uses the slave modport; the fetch/decode side (or a bench) uses master.
interface instr_buffer_if;
  logic             flush;
  logic [1:0]       in_valid;
  logic [1:0][31:0] in_pc;
  logic [1:0][31:0] in_inst;
  logic [1:0]       in_excp;
  logic [1:0][6:0]  in_excp_cause;
  logic             ib_ready;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_pc;
  logic [1:0][31:0] out_inst;
  logic [1:0]       out_excp;
  logic [1:0][6:0]  out_excp_cause;
  logic [1:0]       dec_accept;

  modport master (
    output flush, in_valid, in_pc, in_inst, in_excp, in_excp_cause, dec_accept,
    input  ib_ready, out_valid, out_pc, out_inst, out_excp, out_excp_cause
  );

  modport slave (
    input  flush, in_valid, in_pc, in_inst, in_excp, in_excp_cause, dec_accept,
    output ib_ready, out_valid, out_pc, out_inst, out_excp, out_excp_cause
  );
endinterface

// File: rtl/instr_buffer.sv
// Dual-lane in-order instruction FIFO between fetch and decode, with flush on redirect.
// Optional enqueue-stall counter is built only when IB_STALL_CNT_EN is defined.
module instr_buffer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  instr_buffer_if.slave            ib,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              stall_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0] pc_q    [DEPTH];
  logic [31:0] inst_q  [DEPTH];
  logic        excp_q  [DEPTH];
  logic [6:0]  cause_q [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  logic          ready;
  logic          enq;
  logic          a0, a1;
  logic [AW:0]   e_cnt, d_cnt;
  logic [AW-1:0] wr_idx1;

  // Needs room for a full pair regardless of how many lanes fetch actually drives.
  assign ready       = (count_q <= (AW+1)'(DEPTH - 2));
  assign ib.ib_ready = ready;
  assign count       = count_q;
  assign enq         = ready && !ib.flush;

  // Lane1 lands at tail only when lane0 did not consume it.
  assign wr_idx1 = ib.in_valid[0] ? tail_q + AW'(1) : tail_q;

  always_comb begin
    a0    = ib.dec_accept[0] && (count_q > (AW+1)'(0));
    a1    = ib.dec_accept[1] && a0 && (count_q > (AW+1)'(1));
    d_cnt = (AW+1)'(a0) + (AW+1)'(a1);
    e_cnt = '0;
    if (enq) begin
      e_cnt = (AW+1)'(ib.in_valid[0]) + (AW+1)'(ib.in_valid[1]);
    end
    head_d  = head_q + AW'(d_cnt);
    tail_d  = tail_q + AW'(e_cnt);
    count_d = count_q + e_cnt - d_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst || ib.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is never cleared; visibility is governed by count_q alone.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      if (ib.in_valid[0]) begin
        pc_q[tail_q]    <= ib.in_pc[0];
        inst_q[tail_q]  <= ib.in_inst[0];
        excp_q[tail_q]  <= ib.in_excp[0];
        cause_q[tail_q] <= ib.in_excp_cause[0];
      end
      if (ib.in_valid[1]) begin
        pc_q[wr_idx1]    <= ib.in_pc[1];
        inst_q[wr_idx1]  <= ib.in_inst[1];
        excp_q[wr_idx1]  <= ib.in_excp[1];
        cause_q[wr_idx1] <= ib.in_excp_cause[1];
      end
    end
  end

  always_comb begin
    ib.out_valid      = '0;
    ib.out_pc         = '0;
    ib.out_inst       = '0;
    ib.out_excp       = '0;
    ib.out_excp_cause = '0;
    for (int k = 0; k < 2; k++) begin
      if (count_q > (AW+1)'(k)) begin
        ib.out_valid[k]      = 1'b1;
        ib.out_pc[k]         = pc_q[head_q + AW'(k)];
        ib.out_inst[k]       = inst_q[head_q + AW'(k)];
        ib.out_excp[k]       = excp_q[head_q + AW'(k)];
        ib.out_excp_cause[k] = cause_q[head_q + AW'(k)];
      end
    end
  end

`ifdef IB_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((|ib.in_valid) && !ready && !ib.flush && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_buffer.sv
// Directed self-checking bench for instr_buffer (DEPTH=8): fill, stall, wrap, masking,
// flush priority and exception-tag passthrough.
module tb_instr_buffer;
  logic        clk;
  logic        rst;
  logic [3:0]  count;
  logic [31:0] stall_cnt;
  int          n_cmp;
  int          n_err;

  instr_buffer_if bus ();

  instr_buffer #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ib        (bus),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef IB_STALL_CNT_EN
  localparam logic [31:0] StallExp = 32'd5;
`else
  localparam logic [31:0] StallExp = 32'd0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    bus.in_valid = v;
    bus.in_pc[0] = pc0;
    bus.in_pc[1] = pc1;
    bus.in_inst[0] = ~pc0;
    bus.in_inst[1] = ~pc1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.dec_accept = 2'b00;
    bus.in_excp = 2'b00;
    bus.in_excp_cause = '0;
    drive(2'b00, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_ready", 64'(bus.ib_ready), 64'd1);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_out_pc", 64'(bus.out_pc), 64'd0);

    // Single pair enqueue
    drive(2'b11, 32'h1C00_0000, 32'h1C00_0004);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    chk("enq_out_valid", 64'(bus.out_valid), 64'b11);
    chk("enq_pc0", 64'(bus.out_pc[0]), 64'h1C00_0000);
    chk("enq_pc1", 64'(bus.out_pc[1]), 64'h1C00_0004);
    chk("enq_inst0", 64'(bus.out_inst[0]), 64'hE3FF_FFFF);
    chk("enq_count", 64'(count), 64'd2);

    // Fill to full
    drive(2'b11, 32'h2000_0008, 32'h2000_000C);
    tick();
    drive(2'b11, 32'h2000_0010, 32'h2000_0014);
    tick();
    chk("fill3_count", 64'(count), 64'd6);
    chk("fill3_ready", 64'(bus.ib_ready), 64'd1);
    drive(2'b11, 32'h2000_0018, 32'h2000_001C);
    tick();
    chk("fill4_count", 64'(count), 64'd8);
    chk("fill4_ready", 64'(bus.ib_ready), 64'd0);
    drive(2'b11, 32'hDEAD_0000, 32'hDEAD_0004);
    for (int i = 0; i < 5; i++) tick();
    drive(2'b00, 32'h0, 32'h0);
    chk("stall_count", 64'(count), 64'd8);
    chk("stall_cnt", 64'(stall_cnt), 64'(StallExp));
    chk("stall_head", 64'(bus.out_pc[0]), 64'h1C00_0000);

    // Dequeue down to 5
    bus.dec_accept = 2'b11;
    tick();
    chk("deq2_count", 64'(count), 64'd6);
    chk("deq2_pc0", 64'(bus.out_pc[0]), 64'h2000_0008);
    bus.dec_accept = 2'b01;
    tick();
    chk("deq1_count", 64'(count), 64'd5);
    chk("deq1_pc0", 64'(bus.out_pc[0]), 64'h2000_000C);

    // Flush overrides same-cycle enqueue and dequeue
    bus.flush = 1'b1;
    bus.dec_accept = 2'b11;
    drive(2'b11, 32'h6000_0000, 32'h6000_0004);
    tick();
    bus.flush = 1'b0;
    bus.dec_accept = 2'b00;
    drive(2'b00, 32'h0, 32'h0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_ready", 64'(bus.ib_ready), 64'd1);
    chk("flush_out_pc", 64'(bus.out_pc), 64'd0);
    chk("flush_out_inst", 64'(bus.out_inst), 64'd0);

    // Build count=7 (tail=7), drop one to get count=6, tail=7, head=1
    drive(2'b11, 32'h3000_0000, 32'h3000_0004);
    tick();
    drive(2'b11, 32'h3000_0008, 32'h3000_000C);
    tick();
    drive(2'b11, 32'h3000_0010, 32'h3000_0014);
    tick();
    drive(2'b01, 32'h3000_0018, 32'h0);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    chk("wrap_pre_count", 64'(count), 64'd7);
    chk("wrap_pre_ready", 64'(bus.ib_ready), 64'd0);
    bus.dec_accept = 2'b01;
    tick();
    chk("wrap_pre2_count", 64'(count), 64'd6);
    // Two-lane enqueue writing slots 7 and 0 while draining two
    drive(2'b11, 32'h4000_0000, 32'h4000_0004);
    bus.dec_accept = 2'b11;
    tick();
    drive(2'b00, 32'h0, 32'h0);
    chk("wrap_count", 64'(count), 64'd6);
    chk("wrap_pc0", 64'(bus.out_pc[0]), 64'h3000_000C);
    chk("wrap_pc1", 64'(bus.out_pc[1]), 64'h3000_0010);
    tick();
    chk("wrap_drain1_pc0", 64'(bus.out_pc[0]), 64'h3000_0014);
    chk("wrap_drain1_pc1", 64'(bus.out_pc[1]), 64'h3000_0018);
    tick();
    chk("wrap_new_pc0", 64'(bus.out_pc[0]), 64'h4000_0000);
    chk("wrap_new_pc1", 64'(bus.out_pc[1]), 64'h4000_0004);
    tick();
    bus.dec_accept = 2'b00;
    chk("wrap_empty", 64'(count), 64'd0);

    // Illegal accept masking with count=1
    drive(2'b01, 32'h5000_0000, 32'h0);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    chk("mask_pre_valid", 64'(bus.out_valid), 64'b01);
    bus.dec_accept = 2'b10;
    tick();
    chk("mask10_count", 64'(count), 64'd1);
    bus.dec_accept = 2'b11;
    tick();
    bus.dec_accept = 2'b00;
    chk("mask11_count", 64'(count), 64'd0);
    chk("mask11_valid", 64'(bus.out_valid), 64'b00);

    // Exception tags, then a lane1-only enqueue
    drive(2'b11, 32'h7000_0000, 32'h7000_0004);
    bus.in_excp = 2'b10;
    bus.in_excp_cause[0] = 7'h00;
    bus.in_excp_cause[1] = 7'h08;
    tick();
    bus.in_excp = 2'b00;
    bus.in_excp_cause = '0;
    drive(2'b10, 32'h0, 32'h7000_0100);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    chk("excp_flags", 64'(bus.out_excp), 64'b10);
    chk("excp_cause1", 64'(bus.out_excp_cause[1]), 64'h08);
    chk("excp_cause0", 64'(bus.out_excp_cause[0]), 64'h00);
    chk("lane1only_count", 64'(count), 64'd3);
    bus.dec_accept = 2'b11;
    tick();
    bus.dec_accept = 2'b00;
    chk("lane1only_valid", 64'(bus.out_valid), 64'b01);
    chk("lane1only_pc0", 64'(bus.out_pc[0]), 64'h7000_0100);
    chk("lane1only_pc1_zero", 64'(bus.out_pc[1]), 64'd0);
    chk("stall_kept", 64'(stall_cnt), 64'(StallExp));

    // rst together with flush behaves as rst
    rst = 1'b1;
    bus.flush = 1'b1;
    tick();
    rst = 1'b0;
    bus.flush = 1'b0;
    chk("rst2_count", 64'(count), 64'd0);
    chk("rst2_stall", 64'(stall_cnt), 64'd0);
    chk("rst2_ready", 64'(bus.ib_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
